// File: rtl/tdm_demux.sv
// ============================================================================
// Module      : tdm_demux
// Description : Four-channel TDM demultiplexer. Each sample goes to the
//               round-robin channel or to an explicitly selected channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         auto,
  input  logic [1:0]   s,
  input  logic         clr,
  input  logic [W-1:0] x,
  input  logic         x_vld,
  output logic         x_rdy,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic [3:0]   y_vld,
  output logic [1:0]   cnt,
  output logic         frame
);

  logic       accept;
  logic [1:0] sel;

  assign x_rdy  = en;
  assign accept = x_vld & en;
  assign sel    = auto ? cnt : s;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      y0    <= '0;
      y1    <= '0;
      y2    <= '0;
      y3    <= '0;
      y_vld <= 4'b0000;
      cnt   <= 2'd0;
      frame <= 1'b0;
    end else begin
      y_vld <= 4'b0000;
      frame <= 1'b0;
      if (accept) begin
        case (sel)
          2'd0:    y0 <= x;
          2'd1:    y1 <= x;
          2'd2:    y2 <= x;
          default: y3 <= x;
        endcase
        y_vld <= 4'b0001 << sel;
        frame <= auto && (cnt == 2'd3);
      end
      // Clear wins over increment; the write above still used the old count.
      if (clr)
        cnt <= 2'd0;
      else if (accept && auto)
        cnt <= cnt + 2'd1;
    end
  end

endmodule

`default_nettype wire
